max_pool_2x2: RTL and testbench

//   Streaming 2x2 stride-2 max-pooling stage. Sits directly downstream of the first conv part
//   and consumes its 8-channel packed pixel stream (44x44 after two valid 3x3 convs).

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/max_cmp_lanes.sv | 25 ++
 rtl/max_pool_2x2.sv | 126 ++++++++++++
 tb/tb_max_pool_2x2.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer pipeline.
//   DEF_DATA_WIDHT / DEF_CHANNELS : default sample width and channel count
//   pooled_dim()                  : output dimension of a 2x2 stride-2 pool
//   `CNN_LANE(vec, k, w)          : select lane k of a packed multi-channel vector
`ifndef CNN_PKG_SV
`define CNN_PKG_SV

`define CNN_LANE(vec, k, w) vec[(k)*(w) +: (w)]

package cnn_pkg;

  localparam int unsigned DEF_DATA_WIDHT = 32;
  localparam int unsigned DEF_CHANNELS   = 8;

  function automatic int unsigned pooled_dim(input int unsigned dim);
    return dim / 2;
  endfunction

endpackage

`endif

// File: rtl/max_cmp_lanes.sv
// Combinational per-lane signed maximum of two packed multi-channel vectors.
// Ports:
//   a, b : packed input vectors, CHANNELS lanes of DATA_WIDHT bits
//   y    : per-lane signed max(a, b); a is chosen on ties
module max_cmp_lanes import cnn_pkg::*; #(
  parameter int unsigned DATA_WIDHT = DEF_DATA_WIDHT,
  parameter int unsigned CHANNELS   = DEF_CHANNELS
) (
  input  logic [DATA_WIDHT*CHANNELS-1:0] a,
  input  logic [DATA_WIDHT*CHANNELS-1:0] b,
  output logic [DATA_WIDHT*CHANNELS-1:0] y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if ($signed(`CNN_LANE(a, k, DATA_WIDHT)) >= $signed(`CNN_LANE(b, k, DATA_WIDHT))) begin
        `CNN_LANE(y, k, DATA_WIDHT) = `CNN_LANE(a, k, DATA_WIDHT);
      end else begin
        `CNN_LANE(y, k, DATA_WIDHT) = `CNN_LANE(b, k, DATA_WIDHT);
      end
    end
  end

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max-pooling stage, no backpressure.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   Data_In   : input pixel, CHANNELS signed lanes
//   Valid_In  : Data_In valid this cycle
//   Data_Out  : pooled pixel (holds while Valid_Out is low)
//   Valid_Out : one-cycle pulse per pooled pixel
//   Frame_End : with Valid_Out on the last pooled pixel of a frame
// Build option: define MAXPOOL_RELU_EN to clamp each output lane to max(x, 0).
module max_pool_2x2 import cnn_pkg::*; #(
  parameter int unsigned DATA_WIDHT = DEF_DATA_WIDHT,
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned IMG_WIDTH  = 44,
  parameter int unsigned IMG_HEIGHT = 44
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
  input  logic                           Valid_In,
  output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
  output logic                           Valid_Out,
  output logic                           Frame_End
);

  localparam int unsigned PW    = DATA_WIDHT * CHANNELS;
  localparam int unsigned OUT_W = pooled_dim(IMG_WIDTH);
  localparam int unsigned CW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if ((IMG_WIDTH % 2) != 0 || (IMG_HEIGHT % 2) != 0 || IMG_WIDTH < 2 || IMG_HEIGHT < 2)
  begin : g_bad_dims
    $error("max_pool_2x2: IMG_WIDTH and IMG_HEIGHT must be even and >= 2");
  end

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [PW-1:0] pair_q;
  logic [PW-1:0] line_buf [OUT_W];

  logic [AW-1:0] buf_idx;
  logic [PW-1:0] line_rd;
  logic [PW-1:0] hmax;
  logic [PW-1:0] vmax;
  logic [PW-1:0] pooled;
  logic          col_last;
  logic          row_last;
  logic          emit;

  assign buf_idx  = AW'(col_q >> 1);
  assign line_rd  = line_buf[buf_idx];
  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
  // Bottom-right pixel of a window: odd column in an odd row.
  assign emit     = Valid_In & col_q[0] & row_q[0];

  max_cmp_lanes #(
    .DATA_WIDHT (DATA_WIDHT),
    .CHANNELS   (CHANNELS)
  ) u_cmp_h (
    .a (pair_q),
    .b (Data_In),
    .y (hmax)
  );

  max_cmp_lanes #(
    .DATA_WIDHT (DATA_WIDHT),
    .CHANNELS   (CHANNELS)
  ) u_cmp_v (
    .a (line_rd),
    .b (hmax),
    .y (vmax)
  );

  always_comb begin
    pooled = vmax;
`ifdef MAXPOOL_RELU_EN
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (vmax[k*int'(DATA_WIDHT) + int'(DATA_WIDHT) - 1]) begin
        `CNN_LANE(pooled, k, DATA_WIDHT) = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (Valid_In) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Pair register and line buffer carry no reset so the buffer can map to distributed RAM.
  // An odd-row read of line_buf[i] only ever sees the even-row write from an earlier row.
  always_ff @(posedge clk) begin
    if (Valid_In) begin
      if (!col_q[0]) begin
        pair_q <= Data_In;
      end else if (!row_q[0]) begin
        line_buf[buf_idx] <= hmax;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
      Frame_End <= 1'b0;
    end else begin
      Valid_Out <= emit;
      Frame_End <= emit & col_last & row_last;
      if (emit) begin
        Data_Out <= pooled;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
module tb_max_pool_2x2;

  localparam int DW   = 32;
  localparam int CH   = 8;
  localparam int W    = 44;
  localparam int H    = 44;
  localparam int PW   = DW * CH;
  localparam int NOUT = (W / 2) * (H / 2);

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic [PW-1:0] Data_In  = '0;
  logic          Valid_In = 1'b0;
  logic [PW-1:0] Data_Out;
  logic          Valid_Out;
  logic          Frame_End;

  max_pool_2x2 #(
    .DATA_WIDHT (DW),
    .CHANNELS   (CH),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .Data_Out  (Data_Out),
    .Valid_Out (Valid_Out),
    .Frame_End (Frame_End)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  int            img [2][H][W][CH];
  logic [PW-1:0] exp_q [$];
  logic          exp_fe_q [$];
  logic [PW-1:0] mon_exp;
  logic          mon_fe;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [PW-1:0] rep(input int v);
    logic [PW-1:0] r;
    for (int k = 0; k < CH; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] pack_px(input int f, input int r, input int c);
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = img[f][r][c][k];
    return p;
  endfunction

  function automatic logic [PW-1:0] rand_px();
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = $urandom;
    return p;
  endfunction

  // mode 0: ramp, 1: random, 2: random with fixed signed-compare windows at the top-left
  task automatic gen_frame(input int f, input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < CH; k++) begin
          if (mode == 0) img[f][r][c][k] = r * W + c + k;
          else if ($urandom_range(3) == 0) img[f][r][c][k] = int'($urandom_range(20)) - 10;
          else img[f][r][c][k] = int'($urandom);
        end
    if (mode == 2) begin
      for (int k = 0; k < CH; k++) begin
        img[f][0][0][k] = -5;
        img[f][0][1][k] = -1;
        img[f][1][0][k] = -7;
        img[f][1][1][k] = -3;
        img[f][0][2][k] = int'(32'h7FFF_FFFF);
        img[f][0][3][k] = int'(32'h8000_0000);
        img[f][1][2][k] = 0;
        img[f][1][3][k] = 1;
      end
    end
  endtask

  // Reference: for each 2x2 window the lane-wise maximum of its four samples.
  task automatic push_expected(input int f);
    for (int i = 0; i < H / 2; i++)
      for (int j = 0; j < W / 2; j++) begin
        logic [PW-1:0] v;
        for (int k = 0; k < CH; k++) begin
          int m;
          m = img[f][2*i][2*j][k];
          if (img[f][2*i][2*j+1][k] > m) m = img[f][2*i][2*j+1][k];
          if (img[f][2*i+1][2*j][k] > m) m = img[f][2*i+1][2*j][k];
          if (img[f][2*i+1][2*j+1][k] > m) m = img[f][2*i+1][2*j+1][k];
          v[k*DW +: DW] = relu(m);
        end
        exp_q.push_back(v);
        exp_fe_q.push_back(i == H / 2 - 1 && j == W / 2 - 1);
      end
  endtask

  // spot 1: latency check at pixel (1,1); spot 2: also the fixed signed windows
  task automatic drive_frame(input int f, input int gap_pct, input int stop_r, input int stop_c,
                             input int spot);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int idle;
        if (r > stop_r || (r == stop_r && c > stop_c)) return;
        idle = 0;
        while (gap_pct > 0 && idle < 20 && int'($urandom_range(99)) < gap_pct) begin
          @(negedge clk);
          Valid_In = 1'b0;
          Data_In  = rand_px();
          idle++;
        end
        @(negedge clk);
        Valid_In = 1'b1;
        Data_In  = pack_px(f, r, c);
        if (spot >= 1 && r == 1 && (c == 1 || (spot == 2 && c == 3))) begin
          check_eq("pre_latency_idle", PW'(Valid_Out), '0);
          @(posedge clk);
          #1;
          check_eq("latency_valid", PW'(Valid_Out), PW'(1));
          if (spot == 2 && c == 1) check_eq("neg_window", Data_Out, rep(relu(-1)));
          if (spot == 2 && c == 3) check_eq("extreme_window", Data_Out, rep(int'(32'h7FFF_FFFF)));
        end
      end
  endtask

  task automatic finish_frame(input int want_pulses);
    @(negedge clk);
    Valid_In = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("drain_empty", PW'(exp_q.size()), '0);
    check_eq("pulse_count", PW'(pulses), PW'(want_pulses));
    pulses = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (Valid_Out) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check_eq("stray_pulse", PW'(Valid_Out), '0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_fe  = exp_fe_q.pop_front();
          check_eq("pool_data", Data_Out, mon_exp);
          check_eq("frame_end", PW'(Frame_End), PW'(mon_fe));
        end
      end else if (Frame_End) begin
        check_eq("frame_end_no_valid", PW'(Frame_End), '0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with traffic present: outputs stay cleared
    Valid_In = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Data_In = rand_px();
      @(negedge clk);
      check_eq("rst_valid", PW'(Valid_Out), '0);
      check_eq("rst_data", Data_Out, '0);
      check_eq("rst_fe", PW'(Frame_End), '0);
    end
    @(negedge clk);
    Valid_In = 1'b0;
    rst = 1'b1;

    // Gapless ramp frame
    gen_frame(0, 0);
    push_expected(0);
    drive_frame(0, 0, H - 1, W - 1, 1);
    finish_frame(NOUT);

    // Signed compare windows
    gen_frame(0, 2);
    push_expected(0);
    drive_frame(0, 0, H - 1, W - 1, 2);
    finish_frame(NOUT);

    // Random data with ~40% idle cycles
    gen_frame(0, 1);
    push_expected(0);
    drive_frame(0, 40, H - 1, W - 1, 0);
    finish_frame(NOUT);

    // Reset at row 17, col 30, then a fresh frame
    gen_frame(0, 1);
    push_expected(0);
    drive_frame(0, 0, 17, 30, 0);
    @(negedge clk);
    Valid_In = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("partial_remaining", PW'(exp_q.size()), PW'(NOUT - (8 * (W / 2) + 15)));
    check_eq("partial_pulses", PW'(pulses), PW'(8 * (W / 2) + 15));
    exp_q.delete();
    exp_fe_q.delete();
    pulses = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    gen_frame(1, 1);
    push_expected(1);
    drive_frame(1, 20, H - 1, W - 1, 0);
    finish_frame(NOUT);

    // Two back-to-back frames
    gen_frame(0, 1);
    gen_frame(1, 1);
    push_expected(0);
    push_expected(1);
    drive_frame(0, 0, H - 1, W - 1, 0);
    drive_frame(1, 0, H - 1, W - 1, 0);
    finish_frame(2 * NOUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
